md_sched: RTL

Sequencing controller for the pipeline's multiply/divide unit. It sits in the E stage between the decoded instruction and the iterative mult/div datapath: it issues operations with a one-cycle start pulse, tracks the unit's busy window, owns the architectural HI/LO registers, executes mthi/mtlo, and stalls the D stage whenever a mult/div-class instruction would collide with an in-flight operation. A watchdog returns the controller to idle if the unit never reports completion.

---
 rtl/md_sched.sv | 112 +++++++++++
 1 files changed

// File: rtl/md_sched.sv
// md_sched: E-stage sequencing controller for the iterative multiply/divide unit.
// Issues operations, tracks the busy window, owns HI/LO and stalls D on md collisions.
module md_sched #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  e_op,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        d_is_md,
    input  logic        u_done,
    input  logic [31:0] u_hi,
    input  logic [31:0] u_lo,
    output logic        u_start,
    output logic [1:0]  u_op,
    output logic [31:0] u_a,
    output logic [31:0] u_b,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        err
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    localparam logic [6:0] CNT_LAST = 7'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        err_q, err_d;

    logic is_mul, is_div, is_mt;

    assign is_mul = (e_op == 3'd1) || (e_op == 3'd2);
    assign is_div = (e_op == 3'd3) || (e_op == 3'd4);
    assign is_mt  = (e_op == 3'd5) || (e_op == 3'd6);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        err_d   = err_q;
        u_start = 1'b0;
        u_op    = 2'(e_op - 3'd1);

        unique case (state_q)
            S_IDLE: begin
                // Divide by zero is silently dropped: no issue, no fault.
                if (is_mul || (is_div && (e_rt != '0))) begin
                    u_start = 1'b1;
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else if (e_op == 3'd5) begin
                    hi_d = e_rs;
                end else if (e_op == 3'd6) begin
                    lo_d = e_rs;
                end
            end
            S_WAIT: begin
                if (is_mul || is_div || is_mt) begin
                    err_d = 1'b1;
                end
                if (u_done) begin
                    hi_d    = u_hi;
                    lo_d    = u_lo;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            err_q   <= err_d;
        end
    end

    assign busy  = (state_q == S_WAIT);
    assign stall = d_is_md & (u_start | busy);
    assign u_a   = e_rs;
    assign u_b   = e_rt;
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign err   = err_q;

endmodule
